// File: rtl/bus_arbiter.sv
// Round-robin arbiter that hands one shared master bus to NUM_REQ requesters, one transfer at a time.
// Optional watchdog abort of stalled transfers is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_rw,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [DATA_W-1:0]         bus_data,
  output logic                      bus_rw,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("bus_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   win_q;
  logic [IDX_W-1:0]   win_d;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               rw_q;
  logic               valid_q;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q;
  logic               tmo_q;
`endif

  // Rotating search: the requester right after the last winner has highest priority.
  always_comb begin
    win_d = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            state_q <= BUSY;
            win_q   <= win_d;
            gnt_q   <= NUM_REQ'(1) << win_d;
            addr_q  <= req_addr[int'(win_d)*ADDR_W +: ADDR_W];
            data_q  <= req_data[int'(win_d)*DATA_W +: DATA_W];
            rw_q    <= req_rw[win_d];
            valid_q <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BUSY: begin
          // bus_valid is always high in BUSY, so ready alone completes the transfer.
          if (bus_ready) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= gnt_q;
            last_q  <= win_q;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b1;
            last_q  <= win_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign req_done  = done_q;
  assign bus_addr  = addr_q;
  assign bus_data  = data_q;
  assign bus_rw    = rw_q;
  assign bus_valid = valid_q;
  assign busy      = (state_q == BUSY);
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (legal range 2-8).
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width.
REQ-004 Parameter TIMEOUT_CYC, default 16, SHALL set the watchdog limit in cycles (used only with BUS_ARB_TIMEOUT_EN).
REQ-005 Port clk  input  1  SHALL be the single system clock; all logic updates on posedge.
REQ-006 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-007 Port req_valid  input  NUM_REQ  SHALL carry per-requester transfer requests, held until that requester's req_done.
REQ-008 Port req_addr  input  NUM_REQ*ADDR_W  SHALL carry per-requester addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-009 Port req_data  input  NUM_REQ*DATA_W  SHALL carry per-requester write data, sliced as for req_addr.
REQ-010 Port req_rw  input  NUM_REQ  SHALL carry per-requester direction: 1 = write, 0 = read.
REQ-011 Port req_done  output  NUM_REQ  SHALL pulse one-hot for one cycle when a requester's transfer completes.
REQ-012 Port gnt  output  NUM_REQ  SHALL be the one-hot grant, all-zero when idle.
REQ-013 Ports bus_addr/bus_data/bus_rw/bus_valid  output  ADDR_W/DATA_W/1/1  SHALL drive the master side of the shared bus.
REQ-014 Port bus_ready  input  1  SHALL be the slave ready.
REQ-015 Port busy  output  1  SHALL be high while in state BUSY.
REQ-016 Port timeout_err  output  1  SHALL pulse for one cycle on a watchdog abort; it SHALL be tied 0 without BUS_ARB_TIMEOUT_EN.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-018 In IDLE with any req_valid bit sampled high, the block SHALL go to BUSY at that edge and select the winner by round-robin.
REQ-019 The round-robin search SHALL start at (last_gnt+1) mod NUM_REQ; last_gnt resets to NUM_REQ-1, so requester 0 has first priority after reset.
REQ-020 On the grant edge, gnt, bus_addr, bus_data and bus_rw SHALL be registered from the winner's slice, and bus_valid SHALL go high.
REQ-021 The registered bus fields SHALL stay stable throughout BUSY regardless of requester input changes.
REQ-022 In BUSY, a transfer SHALL complete on the first edge where bus_valid && bus_ready.
REQ-023 On the completing edge: bus_valid -> 0, gnt -> 0, req_done[winner] -> 1 for one cycle, last_gnt <- winner, state -> IDLE.
REQ-024 Latency: request sampled at edge E gives bus_valid high after E; after a completing edge, the earliest re-grant edge is the next one, giving at least one bus_valid-low cycle between transfers.
REQ-025 If a granted requester drops req_valid mid-transfer, the transfer SHALL still complete and req_done SHALL still pulse.
REQ-026 bus_ready SHALL be ignored in IDLE.
REQ-027 Simultaneous requests SHALL be served one per transfer, in rotating order, with no starvation: any held request is granted within NUM_REQ transfers.
REQ-028 bus_data SHALL be driven on reads as well as writes; the slave ignores it when bus_rw = 0.

Reset
REQ-029 When rst is sampled high, the block SHALL set: state IDLE; gnt, req_done, bus_valid, bus_rw, busy and timeout_err to 0; bus_addr and bus_data to 0; last_gnt to NUM_REQ-1; watchdog count to 0.
REQ-030 Reset during BUSY SHALL abort the transfer with no req_done pulse; rst SHALL take priority over every other event on the same edge.

Configuration
REQ-031 With macro BUS_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle without completion.
REQ-032 When that count reaches TIMEOUT_CYC with bus_ready low, the block SHALL: drop bus_valid and gnt, pulse timeout_err, issue no req_done, update last_gnt, and return to IDLE.
REQ-033 Without BUS_ARB_TIMEOUT_EN, no counter SHALL exist and BUSY SHALL wait indefinitely for bus_ready.

Verification
REQ-034 Single request: req_valid=0001, addr 0x1000, data 0xABCD, rw=1, ready high 2 cycles after valid -> one bus write to 0x1000/0xABCD, req_done=0001 for one cycle, gnt back to 0.
REQ-035 All four held requesting from reset, ready always high -> grant order 0,1,2,3,0 with exactly one bus_valid-low cycle between transfers.
REQ-036 Slave stalls ready low 5 cycles with bus fields changing on requester inputs -> bus_addr/bus_data/bus_rw stay constant until completion.
REQ-037 rst asserted on the 3rd BUSY cycle -> all outputs 0 next cycle, no req_done; next grant goes to requester 0.
REQ-038 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, ready held low -> timeout_err pulses once 16 cycles after grant, no req_done; a pending requester 2 is granted next.
REQ-039 Requester 1 drops req_valid mid-transfer while requester 3 requests -> requester 1 still gets req_done, then requester 3 is granted.
